jk_cmd_sequencer: RTL and testbench

- Command sequencer that sits directly upstream of the team's synchronous-set JK flip-flop and drives its J and K inputs.
- Accepts hold/reset/set/toggle commands, each with a repeat count, over a valid/ready handshake.
- Buffers commands in a small FIFO and plays each one onto registered J/K outputs for the requested number of cycles.
- Keeps a shadow model of the downstream flip-flop's Q so the verification bench and system logic can check the FF output against the expected value.

---
 rtl/jk_cmd_if.sv | 12 +
 rtl/jk_cmd_sequencer.sv | 122 ++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_if.sv
// Command handshake bundle between a command source and jk_cmd_sequencer.
interface jk_cmd_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding the J/K inputs of a downstream synchronous JK flip-flop.
// Commands (HOLD/RESET/SET/TOGGLE + repeat count) are queued in a small FIFO and
// played back-to-back onto registered J/K; q_model shadows the flip-flop's Q.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jk_cmd_if.slave                  cmd,
    input  logic                     flush,
    output logic                     J,
    output logic                     K,
    output logic                     busy,
    output logic                     done,
    output logic                     q_model,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CNT_W + 2;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   rem_reg;
    logic               j_reg, k_reg, done_reg, q_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     level_reg;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic               empty, full, push, pop, last;
    logic [1:0]         head_op;
    logic [CNT_W-1:0]   head_cnt;

    assign empty          = (level_reg == '0);
    assign full           = (level_reg == (PTR_W+1)'(DEPTH));
    assign cmd.cmd_ready  = !full && !flush;
    assign push           = cmd.cmd_valid && !full && !flush;
    // The active command is in its final cycle; rem_reg is never zero while driving.
    assign last           = (state_reg == DRIVE) && (rem_reg == CNT_W'(1));
    // Next head is taken either from idle or seamlessly after the last drive cycle.
    assign pop            = !flush && !empty && ((state_reg == IDLE) || last);
    assign head_op        = mem[rd_ptr_reg][ENT_W-1:CNT_W];
    assign head_cnt       = mem[rd_ptr_reg][CNT_W-1:0];

    assign J          = j_reg;
    assign K          = k_reg;
    assign done       = done_reg;
    assign q_model    = q_reg;
    assign fifo_level = level_reg;
    assign busy       = (state_reg == DRIVE) || !empty;

    // FIFO storage write; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd.cmd_op, cmd.cmd_cnt};
        end
    end

    // FIFO pointers and exact occupancy count; flush empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg <= level_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Playback FSM with registered J/K/done and the shadow Q of the downstream FF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            j_reg     <= 1'b0;
            k_reg     <= 1'b0;
            done_reg  <= 1'b0;
            q_reg     <= 1'b0;
        end else begin
            // The FF sees the J/K driven this cycle, flush or not.
            case ({j_reg, k_reg})
                2'b01:   q_reg <= 1'b0;
                2'b10:   q_reg <= 1'b1;
                2'b11:   q_reg <= !q_reg;
                default: q_reg <= q_reg;
            endcase

            if (flush) begin
                state_reg <= IDLE;
                rem_reg   <= '0;
                j_reg     <= 1'b0;
                k_reg     <= 1'b0;
                done_reg  <= 1'b0;
            end else if (pop) begin
                // A zero count still takes one cycle, driven as HOLD.
                state_reg <= DRIVE;
                rem_reg   <= (head_cnt == '0) ? CNT_W'(1) : head_cnt;
                j_reg     <= (head_cnt != '0) && head_op[1];
                k_reg     <= (head_cnt != '0) && head_op[0];
                done_reg  <= (head_cnt <= CNT_W'(1));
            end else if (state_reg == DRIVE) begin
                if (last) begin
                    state_reg <= IDLE;
                    rem_reg   <= '0;
                    j_reg     <= 1'b0;
                    k_reg     <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    rem_reg  <= rem_reg - CNT_W'(1);
                    done_reg <= (rem_reg == CNT_W'(2));
                end
            end
        end
    end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed scenarios followed by a random phase, all
// checked each cycle against a queue-based model of the command playback.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic J, K, busy, done, q_model;
    logic [$clog2(DEPTH):0] fifo_level;

    jk_cmd_if #(.CNT_W(CNT_W)) cmd_bus ();

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_bus),
        .flush      (flush),
        .J          (J),
        .K          (K),
        .busy       (busy),
        .done       (done),
        .q_model    (q_model),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
    } cmd_t;

    // Model: pending commands, and the per-cycle J/K slots of the command in play.
    cmd_t       m_fifo[$];
    logic [1:0] m_slots[$];
    logic       m_q = 1'b0;
    bit         m_known = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        return (m_slots.size() > 0) || (m_fifo.size() > 0);
    endfunction

    function automatic logic [1:0] m_jk();
        logic [1:0] v;
        v = 2'b00;
        if (m_slots.size() > 0) v = m_slots[0];
        return v;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit v, input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                              input bit fl, input bit rn, output bit acc);
        cmd_t c;
        acc = 1'b0;
        if (!rn) begin
            m_fifo.delete();
            m_slots.delete();
            m_q = 1'b0;
            m_known = 1'b1;
            return;
        end
        case (m_jk())
            2'b01:   m_q = 1'b0;
            2'b10:   m_q = 1'b1;
            2'b11:   m_q = ~m_q;
            default: m_q = m_q;
        endcase
        acc = v && (m_fifo.size() < DEPTH) && !fl;
        if (fl) begin
            m_fifo.delete();
            m_slots.delete();
        end else begin
            if (m_slots.size() > 0) void'(m_slots.pop_front());
            if (m_slots.size() == 0 && m_fifo.size() > 0) begin
                c = m_fifo.pop_front();
                if (c.cnt == 0) m_slots.push_back(2'b00);
                else for (int i = 0; i < int'(c.cnt); i++) m_slots.push_back(c.op);
            end
            if (acc) begin
                c.op = op;
                c.cnt = cnt;
                m_fifo.push_back(c);
            end
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, check registers.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input bit fl, input bit rn, output bit acc);
        logic [1:0] jk;
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_cnt   = cnt;
        flush = fl;
        rst_n = rn;
        #1;
        if (m_known) begin
            check("cmd_ready", {7'b0, cmd_bus.cmd_ready}, {7'b0, (m_fifo.size() < DEPTH) && !fl});
            check("busy_pre", {7'b0, busy}, {7'b0, m_busy()});
        end
        model_edge(v, op, cnt, fl, rn, acc);
        if (acc) $display("cycle %0d accept op=%0d cnt=%0d", cyc, op, cnt);
        @(posedge clk);
        #1;
        cyc++;
        jk = m_jk();
        check("J", {7'b0, J}, {7'b0, jk[1]});
        check("K", {7'b0, K}, {7'b0, jk[0]});
        check("done", {7'b0, done}, {7'b0, m_slots.size() == 1});
        check("q_model", {7'b0, q_model}, {7'b0, m_q});
        check("fifo_level", {5'b0, fifo_level}, 8'(m_fifo.size()));
        check("busy", {7'b0, busy}, {7'b0, m_busy()});
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, 1'b0, 1'b1, a);
    endtask

    task automatic reset_cycles(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy() && n < 200) begin
            idle(1);
            n++;
        end
        check("drain_timeout", {7'b0, busy}, 8'h00);
    endtask

    initial begin
        bit acc;
        int tries;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_cnt   = '0;

        // 1: reset, then SET cnt=3
        reset_cycles(2);
        cycle(1'b1, 2'b10, 4'd3, 1'b0, 1'b1, acc);
        idle(6);

        // 2: TOGGLE 4 then RESET 2 back to back from q=0
        reset_cycles(1);
        cycle(1'b1, 2'b11, 4'd4, 1'b0, 1'b1, acc);
        cycle(1'b1, 2'b01, 4'd2, 1'b0, 1'b1, acc);
        idle(8);

        // 3: fill the FIFO behind a long command, fifth command waits for a pop
        cycle(1'b1, 2'b11, 4'd15, 1'b0, 1'b1, acc);
        idle(1);
        for (int k = 0; k < 5; k++) begin
            tries = 0;
            do begin
                cycle(1'b1, 2'(k), 4'(k + 1), 1'b0, 1'b1, acc);
                tries++;
            end while (!acc && tries < 40);
            check("s3_accept", {7'b0, acc}, 8'h01);
            if (k == 3) begin
                check("s3_level_full", {5'b0, fifo_level}, 8'd4);
                check("s3_ready_low", {7'b0, cmd_bus.cmd_ready}, 8'h00);
            end
        end
        drain();

        // 4: HOLD with zero count
        cycle(1'b1, 2'b00, 4'd0, 1'b0, 1'b1, acc);
        idle(3);

        // 5: flush mid TOGGLE 8 with two queued, command offered during flush
        cycle(1'b1, 2'b11, 4'd8, 1'b0, 1'b1, acc);
        cycle(1'b1, 2'b10, 4'd2, 1'b0, 1'b1, acc);
        cycle(1'b1, 2'b01, 4'd3, 1'b0, 1'b1, acc);
        idle(2);
        cycle(1'b1, 2'b10, 4'd5, 1'b1, 1'b1, acc);
        check("s5_J", {7'b0, J}, 8'h00);
        check("s5_level", {5'b0, fifo_level}, 8'h00);
        check("s5_done", {7'b0, done}, 8'h00);
        idle(3);

        // 6: reset during SET 6, then RESET 1
        cycle(1'b1, 2'b10, 4'd6, 1'b0, 1'b1, acc);
        idle(3);
        reset_cycles(1);
        check("s6_q", {7'b0, q_model}, 8'h00);
        cycle(1'b1, 2'b01, 4'd1, 1'b0, 1'b1, acc);
        idle(3);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            bit v, fl, rn;
            logic [1:0] op;
            logic [CNT_W-1:0] cnt;
            v   = ($urandom_range(0, 1) == 1);
            op  = 2'($urandom_range(0, 3));
            cnt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 4));
            fl  = ($urandom_range(0, 29) == 0);
            rn  = ($urandom_range(0, 99) != 0);
            cycle(v, op, cnt, fl, rn, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
